// File: rtl/muldiv_if.sv
// muldiv_if: handshake, operand and HI/LO bus between the EX stage and the mul/div unit
interface muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] num1;
  logic [WIDTH-1:0] num2;
  logic             cancel;
  logic             mthi_we;
  logic             mtlo_we;
  logic [WIDTH-1:0] mt_data;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             stall;
  logic             done;
  modport master (output start, op, num1, num2, cancel, mthi_we, mtlo_we, mt_data,
                  input hi, lo, busy, stall, done);
  modport slave (input start, op, num1, num2, cancel, mthi_we, mtlo_we, mt_data,
                 output hi, lo, busy, stall, done);
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle shift-add multiplier / restoring divider owning HI/LO
module muldiv_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input logic     clk,
  input logic     resetn,
  muldiv_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2;
  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   m;
  logic [2*WIDTH-1:0] acc;
  logic               div_q, dz_q, neg_q, neg_r;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               busy_q, done_q;
  logic               sign1, sign2, go, last, ge;
  logic [WIDTH-1:0]   abs1, abs2, rem_sub, quo, rem, res_hi, res_lo;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_nx, prod;
  // operand magnitudes, one iteration of either algorithm, and sign-corrected results
  always_comb begin
    sign1 = !bus.op[0] & bus.num1[WIDTH-1];
    sign2 = !bus.op[0] & bus.num2[WIDTH-1];
    abs1 = sign1 ? -bus.num1 : bus.num1;
    abs2 = sign2 ? -bus.num2 : bus.num2;
    go = bus.start & (state == IDLE) & !bus.cancel;
    last = cnt == CNT_W'(WIDTH - 1);
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
    ge = {1'b0, acc[2*WIDTH-1:WIDTH-1]} >= {1'b0, m};
    rem_sub = acc[2*WIDTH-2:WIDTH-1] - m;
    acc_nx = div_q ? (ge ? {rem_sub, acc[WIDTH-2:0], 1'b1} : {acc[2*WIDTH-2:0], 1'b0})
                   : {sum, acc[WIDTH-1:1]};
    prod = neg_q ? -acc : acc;
    quo = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    res_hi = div_q ? rem : prod[2*WIDTH-1:WIDTH];
    res_lo = div_q ? (dz_q ? '1 : quo) : prod[WIDTH-1:0];
  end
  // control FSM: IDLE -> RUN (WIDTH iterations) -> FIX -> IDLE, cancel aborts
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == FIX) & !bus.cancel;
      if (state == IDLE) begin
        state <= go ? RUN : IDLE;
        busy_q <= go;
        cnt <= '0;
      end else if (bus.cancel || state == FIX) begin
        state <= IDLE;
        busy_q <= 1'b0;
      end else begin
        state <= last ? FIX : RUN;
        cnt <= cnt + 1'b1;
      end
    end
  end
  // datapath: capture magnitudes and signs at start, iterate in RUN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m <= '0;
      acc <= '0;
      div_q <= 1'b0;
      dz_q <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (go) begin
      m <= bus.op[1] ? abs2 : abs1;
      acc <= {{WIDTH{1'b0}}, bus.op[1] ? abs1 : abs2};
      div_q <= bus.op[1];
      dz_q <= bus.op[1] & (bus.num2 == '0);
      neg_q <= sign1 ^ sign2;
      neg_r <= sign1;
    end else if (state == RUN) begin
      acc <= acc_nx;
    end
  end
  // HI/LO: operation result at FIX, MTHI/MTLO only while idle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (state == FIX && !bus.cancel) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
    end else if (state == IDLE) begin
      if (bus.mthi_we) hi_q <= bus.mt_data;
      if (bus.mtlo_we) lo_q <= bus.mt_data;
    end
  end
  assign bus.stall = go | (state == RUN) | ((state == FIX) & !bus.cancel);
  assign bus.hi = hi_q;
  assign bus.lo = lo_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule
